mc_reg_axi4lite_adapter: RTL and testbench
==========================================

MC_REG_AXI4LITE_ADAPTER -- requirements
Module: mc_reg_axi4lite_adapter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 8, byte address width.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 32, data width, multiple of 8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, register-side wait limit, range 2..255.
REQ-004 The block SHALL have one clock and a synchronous active-low reset: i_clk  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have i_rst_n  input  1  synchronous active-low reset.
REQ-006 The block SHALL have AXI4-Lite write address ports: i_awvalid in 1; o_awready out 1; i_awaddr in ADDRESS_WIDTH.
REQ-007 The block SHALL have AXI4-Lite write data ports: i_wvalid in 1; o_wready out 1; i_wdata in BUS_WIDTH; i_wstrb in BUS_WIDTH/8.
REQ-008 The block SHALL have AXI4-Lite write response ports: o_bvalid out 1; i_bready in 1; o_bresp out 2.
REQ-009 The block SHALL have AXI4-Lite read ports: i_arvalid in 1; o_arready out 1; i_araddr in ADDRESS_WIDTH; o_rvalid out 1; i_rready in 1; o_rdata out BUS_WIDTH; o_rresp out 2.
REQ-010 The block SHALL have register-bus outputs: o_reg_valid out 1; o_reg_write out 1 (1=write); o_reg_address out ADDRESS_WIDTH; o_reg_write_data out BUS_WIDTH; o_reg_strobe out BUS_WIDTH, bit mask driving field read/write masks.
REQ-011 The block SHALL have register-bus inputs: i_reg_ready in 1; i_reg_status in 2 (00 OKAY, 10 SLVERR); i_reg_read_data in BUS_WIDTH.

Function
REQ-012 The block SHALL implement FSM states IDLE, ACCESS, RESPOND; one transaction in flight.
REQ-013 In IDLE, i_awvalid and i_wvalid both high SHALL pulse o_awready and o_wready together for one cycle, capture address/data/strobe, and go to ACCESS.
REQ-014 In IDLE, i_arvalid high without a complete AW+W pair SHALL pulse o_arready for one cycle, capture address, and go to ACCESS; a write pair wins over a simultaneous read.
REQ-015 A lone i_awvalid or lone i_wvalid SHALL NOT be accepted; both readies stay low.
REQ-016 o_reg_strobe SHALL be each i_wstrb bit replicated 8 times for writes and all ones for reads; o_reg_write_data SHALL be zero for reads.
REQ-017 In ACCESS, o_reg_valid SHALL be high with address/strobe/data stable until the cycle i_reg_ready is high, then drop and go to RESPOND.
REQ-018 Latency: acceptance at edge N, o_reg_valid high after N; i_reg_ready at N+1 gives o_bvalid/o_rvalid high after edge N+2.
REQ-019 In RESPOND, o_bvalid (write) or o_rvalid (read) SHALL be held with o_bresp/o_rresp = captured i_reg_status and o_rdata = captured i_reg_read_data until i_bready/i_rready high, then go to IDLE.
REQ-020 Reserved status 01/11 SHALL map to SLVERR (10); o_rdata SHALL be zero when o_rresp is not OKAY.
REQ-021 No ready SHALL be asserted outside IDLE; the cycle after a response handshake is IDLE, giving a minimum 3-cycle turnaround.

Reset
REQ-022 With i_rst_n low at a rising edge, the FSM SHALL enter IDLE and all outputs SHALL be zero after that edge, including mid-transaction; the in-flight transaction is discarded with no response.

Configuration
REQ-023 With macro MC_REG_TIMEOUT_EN defined, an 8-bit counter SHALL count ACCESS cycles; at TIMEOUT_CYCLES without i_reg_ready, o_reg_valid drops, response is SLVERR with o_rdata zero, and the FSM enters RESPOND.
REQ-024 Without MC_REG_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely for i_reg_ready.

Verification
REQ-025 Write 0x10 data 0xA5A5_5A5A wstrb 0x3, i_reg_ready next cycle, status 00 -> o_reg_strobe 0x0000_FFFF, o_bresp 00, o_bvalid after edge N+2.
REQ-026 Read 0x04, i_reg_read_data 0x1234_5678 status 00, i_rready low 3 cycles -> o_rvalid held 4 cycles, o_rdata 0x1234_5678, o_rresp 00.
REQ-027 AW+W and AR valid same cycle -> write accepted first, o_arready low; read accepted only after the B handshake.
REQ-028 Read with i_reg_status 01 -> o_rresp 10, o_rdata 0x0000_0000.
REQ-029 MC_REG_TIMEOUT_EN defined, TIMEOUT_CYCLES 16, i_reg_ready never high -> o_reg_valid high 16 cycles, then o_bresp 10; macro undefined -> o_reg_valid high indefinitely.
REQ-030 i_rst_n low during ACCESS -> o_reg_valid and all readies 0 after that edge; no B/R response issued.

Source files
------------

// File: rtl/mc_reg_axi4lite_adapter_if.sv
// rtl/mc_reg_axi4lite_adapter_if.sv - AXI4-Lite slave and register-bus signal bundle
interface mc_reg_axi4lite_adapter_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32
);
   logic                     i_awvalid;
   logic                     o_awready;
   logic [ADDRESS_WIDTH-1:0] i_awaddr;
   logic                     i_wvalid;
   logic                     o_wready;
   logic [BUS_WIDTH-1:0]     i_wdata;
   logic [BUS_WIDTH/8-1:0]   i_wstrb;
   logic                     o_bvalid;
   logic                     i_bready;
   logic [1:0]               o_bresp;
   logic                     i_arvalid;
   logic                     o_arready;
   logic [ADDRESS_WIDTH-1:0] i_araddr;
   logic                     o_rvalid;
   logic                     i_rready;
   logic [BUS_WIDTH-1:0]     o_rdata;
   logic [1:0]               o_rresp;
   logic                     o_reg_valid;
   logic                     o_reg_write;
   logic [ADDRESS_WIDTH-1:0] o_reg_address;
   logic [BUS_WIDTH-1:0]     o_reg_write_data;
   logic [BUS_WIDTH-1:0]     o_reg_strobe;
   logic                     i_reg_ready;
   logic [1:0]               i_reg_status;
   logic [BUS_WIDTH-1:0]     i_reg_read_data;

   modport slave (
      input  i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
      input  i_arvalid, i_araddr, i_rready,
      input  i_reg_ready, i_reg_status, i_reg_read_data,
      output o_awready, o_wready, o_bvalid, o_bresp,
      output o_arready, o_rvalid, o_rdata, o_rresp,
      output o_reg_valid, o_reg_write, o_reg_address, o_reg_write_data, o_reg_strobe
   );

   modport master (
      output i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
      output i_arvalid, i_araddr, i_rready,
      output i_reg_ready, i_reg_status, i_reg_read_data,
      input  o_awready, o_wready, o_bvalid, o_bresp,
      input  o_arready, o_rvalid, o_rdata, o_rresp,
      input  o_reg_valid, o_reg_write, o_reg_address, o_reg_write_data, o_reg_strobe
   );
endinterface

// File: rtl/mc_reg_axi4lite_adapter.sv
// rtl/mc_reg_axi4lite_adapter.sv - AXI4-Lite slave to single-beat register bus bridge
// Optional register-side wait timeout enabled by macro MC_REG_TIMEOUT_EN.
module mc_reg_axi4lite_adapter #(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   mc_reg_axi4lite_adapter_if.slave bus
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t                   state_q, state_d;
   logic                     is_write_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [BUS_WIDTH-1:0]     wdata_q;
   logic [BUS_WIDTH-1:0]     strobe_q;
   logic [BUS_WIDTH-1:0]     rdata_q;
   logic [1:0]               resp_q;
   logic [BUS_WIDTH-1:0]     wstrb_mask;
   logic                     accept_wr;
   logic                     accept_rd;
   logic                     timeout_hit;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || (BUS_WIDTH % 8) != 0) begin : g_bad_param
      $error("mc_reg_axi4lite_adapter: TIMEOUT_CYCLES or BUS_WIDTH out of range");
   end

   always_comb begin
      wstrb_mask = '0;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         wstrb_mask[i*8 +: 8] = {8{bus.i_wstrb[i]}};
      end
   end

`ifdef MC_REG_TIMEOUT_EN
   logic [7:0] wait_cnt_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wait_cnt_q <= '0;
      end else if (state_q == ACCESS) begin
         wait_cnt_q <= wait_cnt_q + 8'd1;
      end else begin
         wait_cnt_q <= '0;
      end
   end

   // Fires in the last permitted ACCESS cycle so o_reg_valid is high exactly TIMEOUT_CYCLES cycles
   assign timeout_hit = (state_q == ACCESS) && !bus.i_reg_ready &&
                        (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      accept_wr = 1'b0;
      accept_rd = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_awvalid && bus.i_wvalid) begin
               accept_wr = 1'b1;
               state_d   = ACCESS;
            end else if (bus.i_arvalid) begin
               accept_rd = 1'b1;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (bus.i_reg_ready || timeout_hit) state_d = RESPOND;
         end
         RESPOND: begin
            if (is_write_q ? bus.i_bready : bus.i_rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         strobe_q   <= '0;
         rdata_q    <= '0;
         resp_q     <= 2'b00;
      end else begin
         state_q <= state_d;
         if (accept_wr) begin
            is_write_q <= 1'b1;
            addr_q     <= bus.i_awaddr;
            wdata_q    <= bus.i_wdata;
            strobe_q   <= wstrb_mask;
         end else if (accept_rd) begin
            is_write_q <= 1'b0;
            addr_q     <= bus.i_araddr;
            wdata_q    <= '0;
            strobe_q   <= '1;
         end
         // Any non-OKAY status, reserved codes included, is reported as SLVERR with zero data
         if (state_q == ACCESS) begin
            if (bus.i_reg_ready) begin
               resp_q  <= (bus.i_reg_status == 2'b00) ? 2'b00 : 2'b10;
               rdata_q <= (!is_write_q && bus.i_reg_status == 2'b00) ? bus.i_reg_read_data : '0;
            end else if (timeout_hit) begin
               resp_q  <= 2'b10;
               rdata_q <= '0;
            end
         end
      end
   end

   assign bus.o_awready        = accept_wr;
   assign bus.o_wready         = accept_wr;
   assign bus.o_arready        = accept_rd;
   assign bus.o_reg_valid      = (state_q == ACCESS);
   assign bus.o_reg_write      = is_write_q;
   assign bus.o_reg_address    = addr_q;
   assign bus.o_reg_write_data = wdata_q;
   assign bus.o_reg_strobe     = strobe_q;
   assign bus.o_bvalid         = (state_q == RESPOND) && is_write_q;
   assign bus.o_rvalid         = (state_q == RESPOND) && !is_write_q;
   assign bus.o_bresp          = resp_q;
   assign bus.o_rresp          = resp_q;
   assign bus.o_rdata          = rdata_q;
endmodule

// File: tb/tb_mc_reg_axi4lite_adapter.sv
// tb/tb_mc_reg_axi4lite_adapter.sv - directed self-checking bench for mc_reg_axi4lite_adapter
module tb_mc_reg_axi4lite_adapter;
   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   mc_reg_axi4lite_adapter_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bus ();

   mc_reg_axi4lite_adapter #(
      .ADDRESS_WIDTH (8),
      .BUS_WIDTH     (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_awvalid = 0; bus.i_awaddr = '0; bus.i_wvalid = 0; bus.i_wdata = '0;
      bus.i_wstrb = '0; bus.i_bready = 0; bus.i_arvalid = 0; bus.i_araddr = '0;
      bus.i_rready = 0; bus.i_reg_ready = 0; bus.i_reg_status = '0; bus.i_reg_read_data = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      tick(); tick(); tick();
      tests_run++;
      if ({bus.o_awready, bus.o_wready, bus.o_arready, bus.o_reg_valid, bus.o_reg_write,
           bus.o_bvalid, bus.o_rvalid} !== 7'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 0", {bus.o_awready, bus.o_wready,
                  bus.o_arready, bus.o_reg_valid, bus.o_reg_write, bus.o_bvalid, bus.o_rvalid});
      end
      tests_run++;
      if ({bus.o_reg_address, bus.o_reg_write_data, bus.o_reg_strobe, bus.o_rdata,
           bus.o_bresp, bus.o_rresp} !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: addr %h wdata %h strobe %h rdata %h expected all 0",
                  bus.o_reg_address, bus.o_reg_write_data, bus.o_reg_strobe, bus.o_rdata);
      end
      rst_n = 1;
      tick();
   endtask

   task automatic test_lone_channel();
      for (int k = 0; k < 2; k++) begin
         bus.i_awvalid = (k == 0); bus.i_wvalid = (k == 1);
         bus.i_awaddr = 8'h44; bus.i_wdata = 32'h1111_2222; bus.i_wstrb = 4'hF;
         #1;
         tests_run++;
         if ({bus.o_awready, bus.o_wready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL lone_ready[%0d]: got %b expected 00", k, {bus.o_awready, bus.o_wready});
         end
         tick();
         tests_run++;
         if (bus.o_reg_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lone_accept[%0d]: reg_valid %b expected 0", k, bus.o_reg_valid);
         end
         clear_inputs();
         tick();
      end
   endtask

   task automatic test_write();
      bus.i_awvalid = 1; bus.i_awaddr = 8'h10; bus.i_wvalid = 1;
      bus.i_wdata = 32'hA5A5_5A5A; bus.i_wstrb = 4'h3;
      #1;
      tests_run++;
      if ({bus.o_awready, bus.o_wready, bus.o_arready} !== 3'b110) begin
         tests_failed++;
         $display("FAIL wr_ready: got %b expected 110", {bus.o_awready, bus.o_wready, bus.o_arready});
      end
      tick();  // edge N
      bus.i_awvalid = 0; bus.i_wvalid = 0;
      tests_run++;
      if ({bus.o_reg_valid, bus.o_reg_write, bus.o_reg_address, bus.o_reg_strobe,
           bus.o_reg_write_data, bus.o_awready} !== {1'b1, 1'b1, 8'h10, 32'h0000_FFFF, 32'hA5A5_5A5A, 1'b0}) begin
         tests_failed++;
         $display("FAIL wr_regbus: valid %b write %b addr %h strobe %h data %h awready %b expected 1 1 10 0000ffff a5a55a5a 0",
                  bus.o_reg_valid, bus.o_reg_write, bus.o_reg_address, bus.o_reg_strobe,
                  bus.o_reg_write_data, bus.o_awready);
      end
      tick();  // edge N+1
      tests_run++;
      if ({bus.o_reg_valid, bus.o_bvalid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL wr_wait: valid/bvalid %b expected 10", {bus.o_reg_valid, bus.o_bvalid});
      end
      bus.i_reg_ready = 1; bus.i_reg_status = 2'b00;
      tick();  // edge N+2
      bus.i_reg_ready = 0;
      tests_run++;
      if ({bus.o_reg_valid, bus.o_bvalid, bus.o_bresp} !== 4'b0100) begin
         tests_failed++;
         $display("FAIL wr_resp: valid %b bvalid %b bresp %b expected 0 1 00",
                  bus.o_reg_valid, bus.o_bvalid, bus.o_bresp);
      end
      bus.i_bready = 1;
      tick();
      bus.i_bready = 0;
      tests_run++;
      if (bus.o_bvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL wr_bdone: bvalid %b expected 0", bus.o_bvalid);
      end
   endtask

   task automatic test_read_hold();
      bus.i_arvalid = 1; bus.i_araddr = 8'h04;
      #1;
      tests_run++;
      if ({bus.o_awready, bus.o_wready, bus.o_arready} !== 3'b001) begin
         tests_failed++;
         $display("FAIL rd_ready: got %b expected 001", {bus.o_awready, bus.o_wready, bus.o_arready});
      end
      tick();
      bus.i_arvalid = 0;
      tests_run++;
      if ({bus.o_reg_valid, bus.o_reg_write, bus.o_reg_address, bus.o_reg_strobe,
           bus.o_reg_write_data} !== {1'b1, 1'b0, 8'h04, 32'hFFFF_FFFF, 32'h0}) begin
         tests_failed++;
         $display("FAIL rd_regbus: valid %b write %b addr %h strobe %h data %h expected 1 0 04 ffffffff 0",
                  bus.o_reg_valid, bus.o_reg_write, bus.o_reg_address, bus.o_reg_strobe,
                  bus.o_reg_write_data);
      end
      bus.i_reg_ready = 1; bus.i_reg_read_data = 32'h1234_5678; bus.i_reg_status = 2'b00;
      tick();
      bus.i_reg_ready = 0; bus.i_reg_read_data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({bus.o_rvalid, bus.o_rdata, bus.o_rresp} !== {1'b1, 32'h1234_5678, 2'b00}) begin
            tests_failed++;
            $display("FAIL rd_hold[%0d]: rvalid %b rdata %h rresp %b expected 1 12345678 00",
                     i, bus.o_rvalid, bus.o_rdata, bus.o_rresp);
         end
         if (i == 3) bus.i_rready = 1;
         tick();
      end
      bus.i_rready = 0;
      tests_run++;
      if (bus.o_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_rdone: rvalid %b expected 0", bus.o_rvalid);
      end
   endtask

   task automatic test_priority();
      bus.i_awvalid = 1; bus.i_awaddr = 8'h20; bus.i_wvalid = 1;
      bus.i_wdata = 32'hDEAD_BEEF; bus.i_wstrb = 4'hF;
      bus.i_arvalid = 1; bus.i_araddr = 8'h08;
      #1;
      tests_run++;
      if ({bus.o_awready, bus.o_wready, bus.o_arready} !== 3'b110) begin
         tests_failed++;
         $display("FAIL prio_ready: got %b expected 110", {bus.o_awready, bus.o_wready, bus.o_arready});
      end
      tick();
      bus.i_awvalid = 0; bus.i_wvalid = 0;
      tests_run++;
      if ({bus.o_reg_write, bus.o_reg_address, bus.o_arready} !== {1'b1, 8'h20, 1'b0}) begin
         tests_failed++;
         $display("FAIL prio_write: write %b addr %h arready %b expected 1 20 0",
                  bus.o_reg_write, bus.o_reg_address, bus.o_arready);
      end
      bus.i_reg_ready = 1; bus.i_reg_status = 2'b10;
      tick();
      bus.i_reg_ready = 0; bus.i_reg_status = 2'b00;
      bus.i_bready = 1;
      #1;
      tests_run++;
      if ({bus.o_bvalid, bus.o_bresp, bus.o_arready} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL prio_bresp: bvalid %b bresp %b arready %b expected 1 10 0",
                  bus.o_bvalid, bus.o_bresp, bus.o_arready);
      end
      tick();
      bus.i_bready = 0;
      #1;
      tests_run++;
      if (bus.o_arready !== 1'b1) begin
         tests_failed++;
         $display("FAIL prio_read_after_b: arready %b expected 1", bus.o_arready);
      end
      tick();
      bus.i_arvalid = 0;
      tests_run++;
      if ({bus.o_reg_valid, bus.o_reg_write, bus.o_reg_address} !== {1'b1, 1'b0, 8'h08}) begin
         tests_failed++;
         $display("FAIL prio_read: valid %b write %b addr %h expected 1 0 08",
                  bus.o_reg_valid, bus.o_reg_write, bus.o_reg_address);
      end
      bus.i_reg_ready = 1; bus.i_reg_read_data = 32'hCAFE_F00D;
      tick();
      bus.i_reg_ready = 0;
      tests_run++;
      if ({bus.o_rvalid, bus.o_rdata, bus.o_rresp} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin
         tests_failed++;
         $display("FAIL prio_rdata: rvalid %b rdata %h rresp %b expected 1 cafef00d 00",
                  bus.o_rvalid, bus.o_rdata, bus.o_rresp);
      end
      bus.i_rready = 1;
      tick();
      bus.i_rready = 0;
   endtask

   task automatic test_reserved_status();
      logic [1:0] codes [2];
      codes[0] = 2'b01;
      codes[1] = 2'b11;
      for (int k = 0; k < 2; k++) begin
         bus.i_arvalid = 1; bus.i_araddr = 8'h0C;
         tick();
         bus.i_arvalid = 0;
         bus.i_reg_ready = 1; bus.i_reg_status = codes[k]; bus.i_reg_read_data = 32'hFFFF_FFFF;
         tick();
         bus.i_reg_ready = 0; bus.i_reg_status = 2'b00;
         tests_run++;
         if ({bus.o_rvalid, bus.o_rresp, bus.o_rdata} !== {1'b1, 2'b10, 32'h0}) begin
            tests_failed++;
            $display("FAIL reserved_status[%0d]: rvalid %b rresp %b rdata %h expected 1 10 00000000",
                     k, bus.o_rvalid, bus.o_rresp, bus.o_rdata);
         end
         bus.i_rready = 1;
         tick();
         bus.i_rready = 0;
      end
   endtask

   task automatic test_timeout();
      int high_cycles;
      bus.i_awvalid = 1; bus.i_awaddr = 8'h30; bus.i_wvalid = 1;
      bus.i_wdata = 32'h0BAD_0BAD; bus.i_wstrb = 4'hF;
      tick();
      bus.i_awvalid = 0; bus.i_wvalid = 0;
      high_cycles = 0;
      while (bus.o_reg_valid === 1'b1 && high_cycles < 40) begin
         high_cycles++;
         tick();
      end
`ifdef MC_REG_TIMEOUT_EN
      tests_run++;
      if (high_cycles !== 16) begin
         tests_failed++;
         $display("FAIL timeout_len: reg_valid high %0d cycles expected 16", high_cycles);
      end
      tests_run++;
      if ({bus.o_bvalid, bus.o_bresp} !== 3'b110) begin
         tests_failed++;
         $display("FAIL timeout_resp: bvalid %b bresp %b expected 1 10", bus.o_bvalid, bus.o_bresp);
      end
`else
      tests_run++;
      if (high_cycles !== 40) begin
         tests_failed++;
         $display("FAIL no_timeout: reg_valid high %0d cycles expected 40", high_cycles);
      end
      bus.i_reg_ready = 1;
      tick();
      bus.i_reg_ready = 0;
`endif
      bus.i_bready = 1;
      tick();
      bus.i_bready = 0;
   endtask

   task automatic test_reset_mid();
      int resp_seen;
      bus.i_arvalid = 1; bus.i_araddr = 8'h3C;
      tick();
      bus.i_arvalid = 0;
      tick();
      tests_run++;
      if (bus.o_reg_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_access: reg_valid %b expected 1", bus.o_reg_valid);
      end
      rst_n = 0;
      tick();
      tests_run++;
      if ({bus.o_reg_valid, bus.o_awready, bus.o_wready, bus.o_arready, bus.o_bvalid,
           bus.o_rvalid, bus.o_reg_address} !== '0) begin
         tests_failed++;
         $display("FAIL rstmid_clear: valid %b readies %b%b%b b/r %b%b addr %h expected all 0",
                  bus.o_reg_valid, bus.o_awready, bus.o_wready, bus.o_arready,
                  bus.o_bvalid, bus.o_rvalid, bus.o_reg_address);
      end
      rst_n = 1;
      bus.i_reg_ready = 1; bus.i_reg_read_data = 32'h5555_AAAA;
      resp_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.o_rvalid === 1'b1 || bus.o_bvalid === 1'b1) resp_seen++;
      end
      bus.i_reg_ready = 0;
      tests_run++;
      if (resp_seen !== 0) begin
         tests_failed++;
         $display("FAIL rstmid_noresp: response seen %0d cycles expected 0", resp_seen);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_lone_channel();
      test_write();
      test_read_hold();
      test_priority();
      test_reserved_status();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
